chunked_subtractor: RTL and testbench
=====================================

Name: chunked_subtractor

Overview:
- Multi-cycle unsigned subtractor for the FMA datapath: computes in_a - in_b - b_in over WIDTH bits, CHUNK bits per clock, using a registered borrow chain.
- Pairs with the combinational carry-lookahead adder as the effective-subtraction path for mantissa alignment and cancellation.
- Reports the borrow, which is the sign of the result. Can optionally return the magnitude instead of the raw two's-complement difference.
- valid/ready handshake on input and output; one operation in flight.

Parameters:
- WIDTH, 106, operand and result width in bits.
- CHUNK, 16, bits processed per cycle; WIDTH need not be a multiple of CHUNK.
- NCHUNK, (WIDTH+CHUNK-1)/CHUNK (7 at defaults), derived: cycles per pass. Not to be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- in_a  in  WIDTH  minuend (unsigned).
- in_b  in  WIDTH  subtrahend (unsigned).
- b_in  in  1  borrow in.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  result; raw difference, or magnitude with the optional feature.
- b_out  out  1  borrow out: 1 iff in_a < in_b + b_in (unsigned, exact).
- neg  out  1  result negative; equals b_out.

Behaviour:
- Reset (async, active-high): state IDLE, in_ready=1, out_valid=0, diff=0, b_out=0, neg=0, chunk counter=0.
- Reset mid-operation aborts immediately and discards the operation; no partial result is output.
- IDLE:
  - in_valid & in_ready at an edge captures in_a, ~in_b and ~b_in (borrow expressed as the initial carry), clears the counter, and moves to SUB.
  - in_ready drops in the same cycle.
- SUB (NCHUNK cycles):
  - Chunk k (bits k*CHUNK upward) computes a_k + ~b_k + carry into the diff register.
  - The carry is registered between chunks.
  - The last chunk is WIDTH-(NCHUNK-1)*CHUNK bits wide; bits above WIDTH are ignored.
  - After chunk NCHUNK-1: b_out = neg = ~final_carry.
  - Next state is DONE, or NEG if the optional feature is enabled and the borrow is 1.
- NEG (NCHUNK cycles, feature only):
  - diff := ~diff + 1, chunk-serial, low chunk first, with the carry registered.
  - Then DONE.
- DONE:
  - out_valid=1; diff, b_out and neg are stable.
  - On out_valid & out_ready, go to IDLE: out_valid=0 and in_ready=1 from the next cycle.
  - diff, b_out and neg hold their last values until the next capture.
- Latency: out_valid rises NCHUNK+1 edges after the accept edge (2*NCHUNK+1 when NEG runs).
- Throughput: one operation per NCHUNK+2 cycles minimum. No accept and emit in the same cycle.
- in_valid while busy is ignored; the upstream holds its operands.
- Operand registers are captured at accept, so input changes after accept have no effect.
- Boundary cases:
  - in_a == in_b, b_in=0: diff=0, b_out=0.
  - in_a=0, in_b=0, b_in=1: raw diff = all ones, b_out=1; magnitude is 1.
  - in_a=0, in_b=2^WIDTH-1, b_in=1: raw diff=0, b_out=1. The magnitude 2^WIDTH wraps to 0, so diff=0, neg=1 (documented, not an error).
- out_ready held high before out_valid is harmless.

Optional Feature:
- Macro: CHUNKED_SUBTRACTOR_ABS_EN.
- Defined: the NEG state exists. When the borrow is 1, diff returns |in_a - in_b - b_in| mod 2^WIDTH, with neg=1 and latency 2*NCHUNK+1.
- Undefined: no NEG state or logic. diff is always the raw two's-complement difference mod 2^WIDTH and latency is always NCHUNK+1.
- b_out and neg are identical in both builds.

Test Plan:
- Defaults, in_a=1000, in_b=1, b_in=0, out_ready=1 -> diff=999, b_out=0, out_valid exactly 8 edges after accept, in_ready=1 the cycle after the output handshake.
- in_a=5, in_b=9, b_in=0:
  - feature off -> diff=2^106-4, neg=1, latency 8.
  - feature on -> diff=4, neg=1, latency 15.
- in_a=2^106-1, in_b=0, b_in=1 -> diff=2^106-2, b_out=0. Checks carry propagation across all 7 chunks, including the 10-bit top chunk.
- Boundary vectors:
  - in_a=0, in_b=2^106-1, b_in=1 -> b_out=1, diff=0 in both builds.
  - in_a=in_b=0x3FF...F, b_in=0 -> diff=0, b_out=0.
- out_ready held 0 for 5 cycles after out_valid, with in_valid=1 and new operands -> out_valid and diff stable, in_ready=0, new operands accepted only after the handshake, second result correct.
- rst pulsed at cycle 3 of SUB -> out_valid=0, diff=0, in_ready=1 asynchronously. The next operation, 7-3, yields 4 with normal latency.

Source files
------------

// File: rtl/chunked_subtractor.sv
// Multi-cycle unsigned subtractor: in_a - in_b - b_in, CHUNK bits per clock over a registered carry chain.
// Define CHUNKED_SUBTRACTOR_ABS_EN to return the magnitude when the borrow is set (extra NEG pass).
module chunked_subtractor #(
  parameter int WIDTH  = 106,
  parameter int CHUNK  = 16,
  parameter int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             neg
);

  localparam int PW    = NCHUNK * CHUNK;
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef CHUNKED_SUBTRACTOR_ABS_EN
  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

  state_t             state, state_nxt;
  logic [PW-1:0]      a_q, nb_q, diff_q;
  logic               carry_q, b_out_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CHUNK-1:0]   add_x, add_y;
  logic [CHUNK:0]     add_r;
  logic               last;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Results enter at the top and shift down, so after NCHUNK steps chunk k sits at bit k*CHUNK.
  function automatic logic [PW-1:0] shift_in(input logic [PW-1:0]    d,
                                             input logic [CHUNK-1:0] s);
    return (d >> CHUNK) | (PW'(s) << (PW - CHUNK));
  endfunction

  assign last      = (cnt_q == CNT_W'(NCHUNK - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q[WIDTH-1:0];
  assign b_out     = b_out_q;
  assign neg       = b_out_q;

  // Single chunk adder shared by the subtract and negate passes.
  always_comb begin
    add_x = a_q[CHUNK-1:0];
    add_y = nb_q[CHUNK-1:0];
`ifdef CHUNKED_SUBTRACTOR_ABS_EN
    if (state == NEG) begin
      add_x = ~diff_q[CHUNK-1:0];
      add_y = '0;
    end
`endif
    add_r = chunk_add(add_x, add_y, carry_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SUB;
      SUB: if (last) begin
`ifdef CHUNKED_SUBTRACTOR_ABS_EN
        state_nxt = add_r[CHUNK] ? DONE : NEG;
`else
        state_nxt = DONE;
`endif
      end
`ifdef CHUNKED_SUBTRACTOR_ABS_EN
      NEG: if (last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands are zero-extended for a and one-extended for ~b; the padding then passes the
  // carry out of bit WIDTH-1 unchanged, so the final chunk carry is the true WIDTH-bit carry.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q  <= PW'(in_a);
      nb_q <= ~PW'(in_b);
    end else if (state == SUB) begin
      a_q  <= a_q >> CHUNK;
      nb_q <= nb_q >> CHUNK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      b_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          carry_q <= ~b_in;
          cnt_q   <= '0;
        end
        SUB: begin
          diff_q  <= shift_in(diff_q, add_r[CHUNK-1:0]);
          carry_q <= add_r[CHUNK];
          cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
          if (last) begin
            b_out_q <= ~add_r[CHUNK];
            carry_q <= 1'b1;
          end
        end
`ifdef CHUNKED_SUBTRACTOR_ABS_EN
        NEG: begin
          diff_q  <= shift_in(diff_q, add_r[CHUNK-1:0]);
          carry_q <= add_r[CHUNK];
          cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor: directed vectors, backpressure, abort-by-reset, random ops.
module tb_chunked_subtractor;

  localparam int WIDTH  = 106;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
`ifdef CHUNKED_SUBTRACTOR_ABS_EN
  localparam bit ABS_EN = 1'b1;
`else
  localparam bit ABS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             b_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             neg;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_diff;
  logic             exp_b;
  int               exp_lat;

  chunked_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .b_in(b_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .b_out(b_out), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Reference: exact unsigned arithmetic one bit wider than the operands.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic [WIDTH:0] full;
    full     = (WIDTH+1)'(a) - (WIDTH+1)'(b) - (WIDTH+1)'(bin);
    exp_b    = ((WIDTH+1)'(a) < (WIDTH+1)'(b) + (WIDTH+1)'(bin));
    exp_diff = full[WIDTH-1:0];
    if (ABS_EN && exp_b) exp_diff = -exp_diff;
    exp_lat  = (ABS_EN && exp_b) ? 2 * NCHUNK + 1 : NCHUNK + 1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int n;
    model(a, b, bin);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    in_a = a; in_b = b; b_in = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rnd(); in_b = rnd(); b_in = 1'($urandom_range(1));
    check("in_ready_drop", 128'(in_ready), 128'(0));
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic collect(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 3 * NCHUNK + 5) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_out_valid"}, 128'(out_valid), 128'(1));
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_diff"}, 128'(diff), 128'(exp_diff));
    check({tag, "_b_out"}, 128'(b_out), 128'(exp_b));
    check({tag, "_neg"}, 128'(neg), 128'(exp_b));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_out_valid_drop"}, 128'(out_valid), 128'(0));
    check({tag, "_in_ready_back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] a2, b2;
    int seen;

    ones = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_diff", 128'(diff), 128'(0));
    check("rst_b_out", 128'(b_out), 128'(0));
    check("rst_neg", 128'(neg), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    send(WIDTH'(1000), WIDTH'(1), 1'b0);  collect("t1000m1");  handshake("t1000m1");
    send(WIDTH'(5), WIDTH'(9), 1'b0);     collect("t5m9");     handshake("t5m9");
    send(ones, '0, 1'b1);                 collect("tmaxm0b1"); handshake("tmaxm0b1");
    send('0, ones, 1'b1);                 collect("t0mmaxb1"); handshake("t0mmaxb1");
    send(ones >> 2, ones >> 2, 1'b0);     collect("teq");      handshake("teq");
    send('0, '0, 1'b1);                   collect("t0m0b1");   handshake("t0m0b1");

    // Backpressure with a new request waiting upstream.
    out_ready = 1'b0;
    send(rnd(), rnd(), 1'b0);
    collect("bp1");
    a2 = rnd(); b2 = a2 - WIDTH'($urandom_range(50));
    in_a = a2; in_b = b2; b_in = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_out_valid_hold", 128'(out_valid), 128'(1));
      check("bp_diff_hold", 128'(diff), 128'(exp_diff));
      check("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    handshake("bp1");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rnd(); in_b = rnd();
    check("bp2_accept", 128'(in_ready), 128'(0));
    model(a2, b2, 1'b1);
    collect("bp2");
    handshake("bp2");

    // Abort by reset at the third SUB cycle.
    send(rnd() | (WIDTH'(1) << (WIDTH - 1)), rnd() >> 1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_diff", 128'(diff), 128'(0));
    check("abort_b_out", 128'(b_out), 128'(0));
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", 128'(seen), 128'(0));
    send(WIDTH'(7), WIDTH'(3), 1'b0); collect("t7m3"); handshake("t7m3");

    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = rnd();
      case (i % 3)
        0:       rb = rnd();
        1:       rb = ra + WIDTH'($urandom_range(3));
        default: rb = ra - WIDTH'($urandom_range(3));
      endcase
      out_ready = 1'($urandom_range(1));
      send(ra, rb, 1'($urandom_range(1)));
      collect("rand");
      handshake("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
